// File: rtl/dbus_responder_pkg.sv
// Shared types for the data-bus responder: request/response structs, FSM states and sizes.
package dbus_responder_pkg;

  localparam logic [63:0] PCINIT     = 64'h0000_0000_8000_0000;
  localparam int unsigned DBUS_LAT_W = 4;

  typedef logic [63:0] word_t;
  typedef logic [63:0] addr_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  function automatic logic is_misaligned(addr_t addr, msize_t size);
    logic mis;
    case (size)
      MSIZE1:  mis = 1'b0;
      MSIZE2:  mis = addr[0];
      MSIZE4:  mis = |addr[1:0];
      default: mis = |addr[2:0];
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// Request/response bundle between the core's dreq/dresp ports and the responder.
interface dbus_responder_if;
  import dbus_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_responder_lat_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to jitter the responder latency.
module lat_lfsr (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign value = lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], fb};
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Memory end of the dbus handshake: one request at a time, fixed latency, byte-merged writes.
// Optional random extra latency is enabled with `define DBUS_RESP_RAND_LAT_EN.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter addr_t       BASE_ADDR = PCINIT,
  parameter int unsigned LATENCY   = 2
) (
  input  logic             clk,
  input  logic             reset,
  dbus_responder_if.slave  bus,
  output logic             busy,
  output logic             err
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
`ifdef DBUS_RESP_RAND_LAT_EN
  // One spare bit so LATENCY-1 plus three extra cycles never wraps.
  localparam int unsigned CntW = DBUS_LAT_W + 1;
`else
  localparam int unsigned CntW = DBUS_LAT_W;
`endif

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [IdxW-1:0] idx_t;

  localparam cnt_t  LoadBase = cnt_t'(LATENCY - 1);
  localparam addr_t EndAddr  = BASE_ADDR + (addr_t'(MEM_WORDS) << 3);

  word_t mem [MEM_WORDS];

  resp_state_t state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  addr_t       addr_q;
  strobe_t     strobe_q;
  word_t       wdata_q;
  logic        data_ok_q, data_ok_d;
  word_t       rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        addr_ok;
  logic        accept;
  addr_t       cur_addr;
  logic        cur_in_range;
  idx_t        cur_idx;
  word_t       merged;
  logic [1:0]  extra;

`ifdef DBUS_RESP_RAND_LAT_EN
  logic [7:0] lfsr_val;

  lat_lfsr u_lat_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_val)
  );

  assign extra = lfsr_val[1:0];
`else
  assign extra = 2'd0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_ok  = 1'b0;
    accept   = 1'b0;
    cur_addr = addr_q;
    unique case (state_q)
      IDLE: begin
        cur_addr = bus.dreq.addr;
        if (bus.dreq.valid && !reset) begin
          addr_ok = 1'b1;
          accept  = 1'b1;
          cnt_d   = LoadBase + cnt_t'(extra);
          state_d = (cnt_d == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - cnt_t'(1);
        if (cnt_q == cnt_t'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // In IDLE the address comes straight from the bus so LATENCY==1 can read in time.
  assign cur_in_range = (cur_addr >= BASE_ADDR) && (cur_addr < EndAddr);
  assign cur_idx      = idx_t'((cur_addr - BASE_ADDR) >> 3);

  always_comb begin
    merged = mem[cur_idx];
    for (int i = 0; i < 8; i++) begin
      if (strobe_q[i]) begin
        merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    data_ok_d = (state_d == RESP);
    rdata_d   = (state_d == RESP && cur_in_range) ? mem[cur_idx] : '0;
    busy_d    = (state_d != IDLE);
    err_d     = err_q;
    if (accept && (!cur_in_range || is_misaligned(bus.dreq.addr, bus.dreq.size))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      strobe_q  <= '0;
      wdata_q   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      if (accept) begin
        addr_q   <= bus.dreq.addr;
        strobe_q <= bus.dreq.strobe;
        wdata_q  <= bus.dreq.data;
      end
    end
  end

  // Backing store has no reset; a reset on the RESP edge cancels the commit.
  always_ff @(posedge clk) begin
    if (!reset && state_q == RESP && |strobe_q && cur_in_range) begin
      mem[cur_idx] <= merged;
    end
  end

  assign bus.dresp.addr_ok = addr_ok;
  assign bus.dresp.data_ok = data_ok_q;
  assign bus.dresp.data    = rdata_q;
  assign busy              = busy_q;
  assign err               = err_q;

endmodule
